// File: rtl/ram_82s21_pkg.sv
// ram_82s21_pkg: shared FSM states and limits for the 82S21 RAM controller.
package ram_82s21_pkg;
  typedef enum logic [3:0] {
    CLR_SETUP, CLR_PULSE, CLR_HOLD, IDLE, RD, RD_CAP, WR_SETUP, WR_PULSE, WR_HOLD
  } state_e;
  localparam int STARVE_MAX = 4;
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam int WPULSE_MIN = 1;
  localparam int WPULSE_MAX = 15;
  localparam int CNT_W = $clog2(WPULSE_MAX + 1);
endpackage

// File: rtl/ram_82s21_ctl_if.sv
// ram_82s21_ctl_if: requester handshakes plus 82S21 RAM pins; slave is the controller view.
interface ram_82s21_ctl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 2
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic [DATA_W-1:0] rd_data;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              init_done;
  logic [ADDR_W-1:0] ram_a;
  logic [DATA_W-1:0] ram_i;
  logic [DATA_W-1:0] ram_d;
  logic              ram_ce, ram_strobe, ram_wclk_n, ram_we_n;
  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, ram_d,
    input  rd_ack, rd_data, wr_ack, init_done, ram_a, ram_i, ram_ce, ram_strobe, ram_wclk_n, ram_we_n
  );
  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, ram_d,
    output rd_ack, rd_data, wr_ack, init_done, ram_a, ram_i, ram_ce, ram_strobe, ram_wclk_n, ram_we_n
  );
endinterface

// File: rtl/ram_82s21_wseq.sv
// ram_82s21_wseq: counts the WCLK_N low phase of a write; last_o flags the final pulse cycle.
module ram_82s21_wseq
  import ram_82s21_pkg::*;
#(
  parameter int WPULSE = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic setup_i,
  input  logic pulse_i,
  output logic last_o
);
  logic [CNT_W-1:0] cnt_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else if (setup_i) cnt_q <= CNT_W'(WPULSE - 1);
    else if (pulse_i) cnt_q <= cnt_q - 1'b1;
  end
  assign last_o = cnt_q == '0;
endmodule

// File: rtl/ram_82s21_ctl.sv
// ram_82s21_ctl: read/write arbiter and 82S21 control sequencer.
// Define RAM_CLEAR_EN to zero every RAM word after reset before init_done rises.
module ram_82s21_ctl
  import ram_82s21_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 2,
  parameter int WPULSE = 2
) (
  input logic clk,
  input logic reset_n,
  ram_82s21_ctl_if.slave bus
);
  state_e state_q;
  logic [ADDR_W-1:0] a_q;
  logic [DATA_W-1:0] i_q, rd_data_q;
  logic ce_q, strobe_q, wclk_n_q, we_n_q, rd_ack_q, wr_ack_q;
  logic [STARVE_W-1:0] starve_q;
  logic ready, rd_go, wr_go, last;
`ifdef RAM_CLEAR_EN
  logic init_q;
  assign ready = init_q;
  assign bus.init_done = init_q;
`else
  assign ready = 1'b1;
  assign bus.init_done = 1'b1;
`endif
  // a starved write overrides the default read priority
  assign rd_go = state_q == IDLE && ready && bus.rd_req && !(bus.wr_req && starve_q == STARVE_W'(STARVE_MAX));
  assign wr_go = state_q == IDLE && ready && bus.wr_req && !rd_go;
  ram_82s21_wseq #(.WPULSE(WPULSE)) u_wseq (
    .clk     (clk),
    .reset_n (reset_n),
    .setup_i (state_q inside {WR_SETUP, CLR_SETUP}),
    .pulse_i (state_q inside {WR_PULSE, CLR_PULSE}),
    .last_o  (last)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q <= '0;
      i_q <= '0;
      rd_data_q <= '0;
      ce_q <= 1'b0;
      strobe_q <= 1'b0;
      wclk_n_q <= 1'b1;
      we_n_q <= 1'b1;
      rd_ack_q <= 1'b0;
      wr_ack_q <= 1'b0;
      starve_q <= '0;
`ifdef RAM_CLEAR_EN
      init_q <= 1'b0;
`endif
    end else begin
      rd_ack_q <= 1'b0;
      wr_ack_q <= 1'b0;
      if (!bus.wr_req || wr_go) starve_q <= '0;
      else if (rd_go) starve_q <= starve_q + 1'b1;
      case (state_q)
        IDLE: begin
`ifdef RAM_CLEAR_EN
          if (!init_q) begin
            state_q <= CLR_SETUP;
            a_q <= '0;
            i_q <= '0;
            ce_q <= 1'b1;
          end else
`endif
          if (rd_go) begin
            state_q <= RD;
            a_q <= bus.rd_addr;
            ce_q <= 1'b1;
            strobe_q <= 1'b1;
          end else if (wr_go) begin
            state_q <= WR_SETUP;
            a_q <= bus.wr_addr;
            i_q <= bus.wr_data;
            ce_q <= 1'b1;
            we_n_q <= 1'b0;
          end
        end
        RD: begin
          state_q <= RD_CAP;
          rd_data_q <= bus.ram_d;
          rd_ack_q <= 1'b1;
        end
        RD_CAP: begin
          state_q <= IDLE;
          ce_q <= 1'b0;
          strobe_q <= 1'b0;
        end
        WR_SETUP: begin
          state_q <= WR_PULSE;
          wclk_n_q <= 1'b0;
        end
        WR_PULSE: if (last) begin
          state_q <= WR_HOLD;
          wclk_n_q <= 1'b1;
          wr_ack_q <= 1'b1;
        end
        WR_HOLD: begin
          state_q <= IDLE;
          ce_q <= 1'b0;
          we_n_q <= 1'b1;
        end
`ifdef RAM_CLEAR_EN
        // WE_N drops with WCLK_N so the address may advance between words
        CLR_SETUP: begin
          state_q <= CLR_PULSE;
          wclk_n_q <= 1'b0;
          we_n_q <= 1'b0;
        end
        CLR_PULSE: if (last) begin
          state_q <= CLR_HOLD;
          wclk_n_q <= 1'b1;
        end
        CLR_HOLD: begin
          we_n_q <= 1'b1;
          if (&a_q) begin
            state_q <= IDLE;
            ce_q <= 1'b0;
            init_q <= 1'b1;
          end else begin
            state_q <= CLR_SETUP;
            a_q <= a_q + 1'b1;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.rd_ack = rd_ack_q;
  assign bus.rd_data = rd_data_q;
  assign bus.wr_ack = wr_ack_q;
  assign bus.ram_a = a_q;
  assign bus.ram_i = i_q;
  assign bus.ram_ce = ce_q;
  assign bus.ram_strobe = strobe_q;
  assign bus.ram_wclk_n = wclk_n_q;
  assign bus.ram_we_n = we_n_q;
endmodule

// File: tb/tb_ram_82s21_ctl.sv
// tb_ram_82s21_ctl: scoreboard bench for ram_82s21_ctl with a behavioural 82S21 bank.
// Covers both builds; define RAM_CLEAR_EN to exercise the post-reset clear.
module tb_ram_82s21_ctl;
  localparam int AW = 5;
  localparam int DW = 2;
  localparam int WP = 3;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;
  ram_82s21_ctl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  ram_82s21_ctl #(.ADDR_W(AW), .DATA_W(DW), .WPULSE(WP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );
  logic [DW-1:0] mem [32];
  assign bus.ram_d = (bus.ram_ce && bus.ram_strobe) ? mem[bus.ram_a] : '0;
  always @(posedge clk)
    if (bus.ram_ce && !bus.ram_we_n && !bus.ram_wclk_n) mem[bus.ram_a] <= bus.ram_i;
  typedef struct packed {
    logic is_wr;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb[$];
  logic [DW-1:0] exp_mem [32];
  int n_tot = 0;
  int n_bad = 0;
  int ack_at, strb, wlo, welo, n;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  logic [AW+DW-1:0] prev_ai = '0;
  logic prev_we_n = 1'b1;
  always @(negedge clk) begin
    if (!prev_we_n && !bus.ram_we_n) check("addr_hold", 32'({bus.ram_a, bus.ram_i}), 32'(prev_ai));
    if (!bus.ram_we_n) check("strobe_in_wr", 32'(bus.ram_strobe), 32'd0);
    if (reset_n && (bus.rd_ack || bus.wr_ack)) begin
      if (sb.size() == 0) check("unexp_ack", 32'({bus.rd_ack, bus.wr_ack}), 32'd0);
      else begin
        check("ack_kind", 32'(bus.wr_ack), 32'(sb[0].is_wr));
        if (!sb[0].is_wr) check("rd_data", 32'(bus.rd_data), 32'(sb[0].data));
        void'(sb.pop_front());
      end
    end
    prev_ai <= {bus.ram_a, bus.ram_i};
    prev_we_n <= bus.ram_we_n;
  end
  task automatic xact(input bit is_wr, input int a, input logic [DW-1:0] d,
                      output int ack_k, output int s_n, output int wl_n, output int we_n);
    if (is_wr) begin
      exp_mem[a] = d;
      sb.push_back('{1'b1, d});
    end else sb.push_back('{1'b0, exp_mem[a]});
    @(posedge clk); #1;
    if (is_wr) begin
      bus.wr_req = 1'b1;
      bus.wr_addr = AW'(a);
      bus.wr_data = d;
    end else begin
      bus.rd_req = 1'b1;
      bus.rd_addr = AW'(a);
    end
    ack_k = -1;
    s_n = 0;
    wl_n = 0;
    we_n = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      s_n += int'(bus.ram_strobe);
      wl_n += int'(!bus.ram_wclk_n);
      we_n += int'(!bus.ram_we_n);
      if (bus.rd_ack || bus.wr_ack) begin
        ack_k = k;
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b0;
      end
    end
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b0;
  endtask
`ifdef RAM_CLEAR_EN
  int cyc, got;
  bit early;
  task automatic wait_init(output int c, output bit e);
    c = 0;
    e = 1'b0;
    while (!bus.init_done && c < 400) begin
      @(posedge clk); #1;
      c++;
      if (bus.rd_ack && !bus.init_done) e = 1'b1;
    end
  endtask
`endif
  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
  initial begin
    reset_n = 1'b0;
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b0;
    bus.rd_addr = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    for (int a = 0; a < 32; a++) exp_mem[a] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ce", 32'(bus.ram_ce), 32'd0);
    check("rst_strobe", 32'(bus.ram_strobe), 32'd0);
    check("rst_wclk_n", 32'(bus.ram_wclk_n), 32'd1);
    check("rst_we_n", 32'(bus.ram_we_n), 32'd1);
    check("rst_a_i", 32'({bus.ram_a, bus.ram_i}), 32'd0);
    check("rst_acks", 32'({bus.rd_ack, bus.wr_ack}), 32'd0);
    check("rst_rd_data", 32'(bus.rd_data), 32'd0);
`ifdef RAM_CLEAR_EN
    check("rst_init_done", 32'(bus.init_done), 32'd0);
    reset_n = 1'b1;
    wait_init(cyc, early);
    check("init_cyc", 32'(cyc), 32'(32 * (WP + 2) + 1));
`else
    check("rst_init_done", 32'(bus.init_done), 32'd1);
    reset_n = 1'b1;
`endif
    for (int a = 0; a < 32; a++) begin
      xact(1'b1, a, DW'(a ^ (a >> 2)), ack_at, strb, wlo, welo);
      check("fill_wr_lat", 32'(ack_at), 32'd5);
    end
    xact(1'b1, 5, 2'b10, ack_at, strb, wlo, welo);
    xact(1'b0, 5, '0, ack_at, strb, wlo, welo);
    check("rd_lat", 32'(ack_at), 32'd2);
    check("rd_strobe_cyc", 32'(strb), 32'd2);
    check("rd_we_cyc", 32'(welo), 32'd0);
    xact(1'b1, 31, 2'b11, ack_at, strb, wlo, welo);
    check("wr_lat", 32'(ack_at), 32'd5);
    check("wr_wclk_cyc", 32'(wlo), 32'(WP));
    check("wr_we_cyc", 32'(welo), 32'(WP + 2));
    check("wr_strobe_cyc", 32'(strb), 32'd0);
    xact(1'b0, 31, '0, ack_at, strb, wlo, welo);
    check("rd31_lat", 32'(ack_at), 32'd2);
    exp_mem[9] = 2'b01;
    for (int i = 0; i < 2; i++) begin
      repeat (4) sb.push_back('{1'b0, exp_mem[7]});
      sb.push_back('{1'b1, 2'b01});
    end
    @(posedge clk); #1;
    bus.rd_req = 1'b1;
    bus.rd_addr = 5'd7;
    bus.wr_req = 1'b1;
    bus.wr_addr = 5'd9;
    bus.wr_data = 2'b01;
    n = 0;
    for (int k = 0; k < 120 && n < 10; k++) begin
      @(posedge clk); #1;
      n += int'(bus.rd_ack) + int'(bus.wr_ack);
    end
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b0;
    check("arb_acks", 32'(n), 32'd10);
    xact(1'b0, 9, '0, ack_at, strb, wlo, welo);
    @(posedge clk); #1;
    bus.wr_req = 1'b1;
    bus.wr_addr = 5'd20;
    bus.wr_data = 2'b01;
    repeat (2) @(posedge clk);
    #1;
    check("mid_pulse", 32'(bus.ram_wclk_n), 32'd0);
    reset_n = 1'b0;
    #1;
    check("arst_wclk_n", 32'(bus.ram_wclk_n), 32'd1);
    check("arst_we_n", 32'(bus.ram_we_n), 32'd1);
    check("arst_ce", 32'(bus.ram_ce), 32'd0);
    check("arst_wr_ack", 32'(bus.wr_ack), 32'd0);
    bus.wr_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
`ifdef RAM_CLEAR_EN
    for (int a = 0; a < 32; a++) exp_mem[a] = '0;
    bus.rd_req = 1'b1;
    bus.rd_addr = 5'd3;
    sb.push_back('{1'b0, 2'b00});
    reset_n = 1'b1;
    wait_init(cyc, early);
    check("init_cyc2", 32'(cyc), 32'(32 * (WP + 2) + 1));
    check("clr_early_ack", 32'(early), 32'd0);
    got = 0;
    for (int k = 0; k < 10 && got == 0; k++) begin
      @(posedge clk); #1;
      if (bus.rd_ack) got = 1;
    end
    bus.rd_req = 1'b0;
    check("clr_rd_ack", 32'(got), 32'd1);
`else
    reset_n = 1'b1;
`endif
    for (int a = 0; a < 32; a++) begin
`ifndef RAM_CLEAR_EN
      if (a == 20) continue;
`endif
      xact(1'b0, a, '0, ack_at, strb, wlo, welo);
      check("sweep_lat", 32'(ack_at), 32'd2);
    end
    repeat (3) @(posedge clk);
    #1;
    check("sb_left", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule

// File: doc/ram_82s21_ctl.md
# ram_82s21_ctl

Sequencer/arbiter for a bank of 82S21 32x2 write-while-read bipolar RAMs. Shares the bank between a read requester (processor-side lookup) and a write requester (spy/debug load path). Generates the RAM control signals (CE, STROBE, WCLK_N, WE_N) with guaranteed address/data setup and hold around the write pulse. Optionally clears the whole RAM after reset.

## Interface
- ADDR_W, 5, RAM address width (32 words)
- DATA_W, 2, bank data width (multiple of 2; one 82S21 per 2 bits)
- WPULSE, 2, WCLK_N low time in clk cycles (1..15)
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- rd_req  in  1  read request, held until rd_ack
- rd_addr  in  ADDR_W  read address
- rd_ack  out  1  one-cycle pulse; rd_data valid this cycle
- rd_data  out  DATA_W  registered read data, holds until next rd_ack
- wr_req  in  1  write request, held until wr_ack
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_ack  out  1  one-cycle pulse when write complete
- init_done  out  1  high when bank is usable
- ram_a  out  ADDR_W  RAM address
- ram_i  out  DATA_W  RAM write data
- ram_d  in  DATA_W  RAM read data
- ram_ce, ram_strobe  out  1  chip enable, read strobe (active high)
- ram_wclk_n, ram_we_n  out  1  write clock, write enable (active low)

## Operation
- States: CLR_SETUP, CLR_PULSE, CLR_HOLD (clear feature only), IDLE, RD, RD_CAP, WR_SETUP, WR_PULSE, WR_HOLD.
- Reset values: ram_ce 0, ram_strobe 0, ram_wclk_n 1, ram_we_n 1, ram_a 0, ram_i 0, rd_ack 0, wr_ack 0, rd_data 0; init_done 0 with clear, 1 without.
- Requests sampled only in IDLE. Once granted, a transaction completes even if its req drops.
- Arbitration: read wins on simultaneous request, except when starve counter = 4 (four consecutive read grants with wr_req pending), then write wins and counter clears. Counter clears on any write grant or when wr_req low; saturates at 4.
- Read: IDLE->RD (ram_a=rd_addr, ram_ce=1, ram_strobe=1) ->RD_CAP (rd_data<=ram_d, rd_ack=1) ->IDLE.
- Write: IDLE->WR_SETUP (ram_a, ram_i latched, ram_ce=1, ram_we_n=0, ram_wclk_n=1) ->WR_PULSE for WPULSE cycles (ram_wclk_n=0) ->WR_HOLD (ram_wclk_n=1, ram_we_n=0, wr_ack=1) ->IDLE.
- ram_a/ram_i never change while ram_we_n=0. ram_strobe is 0 during writes.
- Write then read to same address returns new data.

## Timing
- Read grant at edge N: ram_strobe high cycle N..N+1, rd_ack and rd_data valid at edge N+2. Latency 2, occupancy 2 cycles.
- Write occupancy WPULSE+2 cycles; wr_ack in last cycle.
- Back-to-back: next grant at the edge leaving RD_CAP/WR_HOLD is not possible; IDLE lasts >=1 cycle between transactions.
- Reset asserted mid-transaction: all outputs return to reset values immediately; pending transaction is lost, no ack.

## Configuration
- RAM_CLEAR_EN defined: after reset release, walk addresses 0..2^ADDR_W-1 writing all-zero data using write phase timing; requests are not granted (not acked) meanwhile; init_done rises at edge after the final CLR_HOLD; reset mid-clear restarts from address 0.
- Undefined: CLR states absent, FSM enters IDLE from reset, init_done tied 1.

## Structure
- Package ram_82s21_pkg: state enum, STARVE_MAX=4 constant, WPULSE range limits.
- Sub-module ram_82s21_wseq: write phase timer (setup/pulse/hold with WPULSE counter), shared by clear and normal write paths.

## Test plan
- Read addr 5 after preloading 2'b10 -> rd_ack at edge N+2, rd_data=2'b10, ram_strobe high exactly 2 cycles.
- Write addr 31 data 2'b11, WPULSE=3 -> ram_wclk_n low exactly 3 cycles, ram_we_n low 5 cycles, wr_ack in cycle 5; subsequent read returns 2'b11.
- rd_req and wr_req held continuously -> reads granted 4 times, then one write, pattern repeats.
- RAM_CLEAR_EN, preload garbage -> init_done after 32*(WPULSE+2)+1 cycles; every address reads 0; rd_req during clear not acked until after.
- reset_n low during WR_PULSE -> ram_wclk_n=1, ram_we_n=1, ram_ce=0 immediately, no wr_ack.
